// File: rtl/alu_pipe.sv
// Registered, valid/ready-handshaked ALU with N/Z/C/V flags.
// Multiplies run on an iterative shift-add engine, one multiplier bit per cycle.
module alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned EW = WIDTH + 1;

  localparam logic [3:0] OP_NOTA  = 4'b0000;
  localparam logic [3:0] OP_NOTB  = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_XNOR  = 4'b0101;
  localparam logic [3:0] OP_ADD   = 4'b0110;
  localparam logic [3:0] OP_SUB   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_SLT   = 4'b1011;
  localparam logic [3:0] OP_SLTU  = 4'b1100;
  localparam logic [3:0] OP_MUL   = 4'b1101;
  localparam logic [3:0] OP_MULHU = 4'b1110;
  localparam logic [3:0] OP_PASSB = 4'b1111;

  typedef enum logic {ST_IDLE, ST_MUL} state_e;

  state_e           state, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             valid_q, valid_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             hi_q, hi_d;

  logic [WIDTH:0]   add_full, sub_full;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [PW-1:0]    acc_step;
  logic [WIDTH-1:0] mul_res;
  logic             is_mul, accept;

  assign out_result = result_q;
  assign out_flags  = flags_q;
  assign out_valid  = valid_q;
  assign busy       = (state == ST_MUL);
  // A held result blocks issue unless the consumer takes it on this same edge.
  assign in_ready   = reset_n && (state == ST_IDLE) && (!valid_q || out_ready);
  assign is_mul     = (in_op == OP_MUL) || (in_op == OP_MULHU);
  assign accept     = in_valid && in_ready;

  // Single-cycle datapath
  always_comb begin
    add_full = {1'b0, in_a} + {1'b0, in_b};
    sub_full = {1'b0, in_a} + {1'b0, ~in_b} + EW'(1);
    shamt    = in_b[SHW-1:0];
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (in_op)
      OP_NOTA:  alu_res = ~in_a;
      OP_NOTB:  alu_res = ~in_b;
      OP_AND:   alu_res = in_a & in_b;
      OP_OR:    alu_res = in_a | in_b;
      OP_XOR:   alu_res = in_a ^ in_b;
      OP_XNOR:  alu_res = ~(in_a ^ in_b);
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SLL:   alu_res = in_a << shamt;
      OP_SRL:   alu_res = in_a >> shamt;
      OP_SRA:   alu_res = $signed(in_a) >>> shamt;
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_PASSB: alu_res = in_b;
      default:  alu_res = '0;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_res  = hi_q ? acc_step[PW-1:WIDTH] : acc_step[WIDTH-1:0];
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state;
    result_d = result_q;
    flags_d  = flags_q;
    valid_d  = valid_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            acc_d    = '0;
            mcand_d  = PW'(in_a);
            mplier_d = in_b;
            hi_d     = (in_op == OP_MULHU);
            cnt_d    = '0;
            valid_d  = 1'b0;
            state_d  = ST_MUL;
          end else begin
            result_d = alu_res;
            flags_d  = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            valid_d  = 1'b1;
          end
        end else if (out_ready) begin
          valid_d = 1'b0;
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          result_d = mul_res;
          flags_d  = {mul_res[WIDTH-1], (mul_res == '0), 2'b00};
          valid_d  = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
    end
  end

endmodule
